// File: rtl/fight_referee.sv
// Round referee for the fighting game: frame-rate hit integration, kick sequencing,
// health bookkeeping and the FIGHT / KO / RESET round state machine.
module fight_referee #(
  parameter int unsigned MAX_HEALTH     = 300,
  parameter int unsigned DAMAGE         = 100,
  parameter int unsigned INVULN_FRAMES  = 30,
  parameter int unsigned KICK_FRAMES    = 8,
  parameter int unsigned KICK_COOLDOWN  = 16,
  parameter int unsigned KO_HOLD_FRAMES = 120,
  parameter int unsigned BAR_RIGHT_EDGE = 640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       p1_hit_px,
  input  logic       p2_hit_px,
  input  logic       p1_kick_btn,
  input  logic       p2_kick_btn,
  output logic       p1_kick_active,
  output logic       p2_kick_active,
  output logic [9:0] p1_health,
  output logic [9:0] p2_health,
  output logic [9:0] p2_bar_xpos,
  output logic [1:0] round_state,
  output logic [1:0] winner,
  output logic       round_reset
);

  localparam int unsigned KickMax = (KICK_FRAMES > KICK_COOLDOWN) ? KICK_FRAMES : KICK_COOLDOWN;
  localparam int unsigned InvW    = $clog2(INVULN_FRAMES + 2);
  localparam int unsigned KickW   = $clog2(KickMax + 2);
  localparam int unsigned KoW     = $clog2(KO_HOLD_FRAMES + 2);

  localparam logic [9:0]       HealthMax    = 10'(MAX_HEALTH);
  localparam logic [9:0]       Dmg          = 10'(DAMAGE);
  localparam logic [9:0]       BarEdge      = 10'(BAR_RIGHT_EDGE);
  localparam logic [9:0]       BarReset     = 10'(BAR_RIGHT_EDGE - MAX_HEALTH);
  localparam logic [InvW-1:0]  InvLoad      = InvW'(INVULN_FRAMES);
  localparam logic [KickW-1:0] KickActLoad  = KickW'(KICK_FRAMES - 1);
  localparam logic [KickW-1:0] KickCoolLoad = KickW'(KICK_COOLDOWN - 1);
  localparam logic [KoW-1:0]   KoLoad       = KoW'(KO_HOLD_FRAMES);

  typedef enum logic [1:0] {StFight = 2'd0, StKo = 2'd1, StReset = 2'd2} round_e;
  typedef enum logic [1:0] {KickIdle = 2'd0, KickActive = 2'd1, KickCool = 2'd2} kick_e;

  round_e                round_q, round_d;
  logic [1:0]            winner_q, winner_d;
  logic                  round_reset_q, round_reset_d;
  logic [KoW-1:0]        ko_cnt_q, ko_cnt_d;
  logic [1:0][9:0]       health_q, health_d;
  logic [9:0]            bar_q, bar_d;
  logic [1:0][InvW-1:0]  inv_q, inv_d;
  logic [1:0]            hit_q, hit_d;
  logic [1:0]            btn_q, btn_d;
  logic [1:0][KickW-1:0] kcnt_q, kcnt_d;
  kick_e                 kick_q [2];
  kick_e                 kick_d [2];

  logic [1:0] hit_px;
  logic [1:0] btn;

  assign hit_px = {p2_hit_px, p1_hit_px};
  assign btn    = {p2_kick_btn, p1_kick_btn};

  always_comb begin
    round_d       = round_q;
    winner_d      = winner_q;
    ko_cnt_d      = ko_cnt_q;
    round_reset_d = 1'b0;
    health_d      = health_q;
    inv_d         = inv_q;
    hit_d         = hit_q;
    btn_d         = btn_q;
    kcnt_d        = kcnt_q;
    for (int i = 0; i < 2; i++) begin
      kick_d[i] = kick_q[i];
    end

    // Sticky per-frame hit flags, consumed on the tick; damage is compare-before-subtract.
    for (int i = 0; i < 2; i++) begin
      if (frame_tick) begin
        hit_d[i] = 1'b0;
        btn_d[i] = btn[i];
        if (round_q == StFight && hit_q[i] && inv_q[i] == '0) begin
          health_d[i] = (health_q[i] > Dmg) ? health_q[i] - Dmg : '0;
          inv_d[i]    = InvLoad;
        end else if (inv_q[i] != '0) begin
          inv_d[i] = inv_q[i] - 1'b1;
        end
      end else if (round_q == StFight && hit_px[i]) begin
        hit_d[i] = 1'b1;
      end
    end

    unique case (round_q)
      StFight: begin
        if (frame_tick && (health_d[0] == '0 || health_d[1] == '0)) begin
          round_d  = StKo;
          winner_d = {health_d[0] == '0, health_d[1] == '0};
          ko_cnt_d = KoLoad;
        end
      end
      StKo: begin
        if (frame_tick) begin
          ko_cnt_d = ko_cnt_q - 1'b1;
          if (ko_cnt_q <= KoW'(1)) begin
            round_d       = StReset;
            round_reset_d = 1'b1;
            health_d      = {HealthMax, HealthMax};
            winner_d      = '0;
            inv_d         = '0;
            hit_d         = '0;
            ko_cnt_d      = '0;
          end
        end
      end
      StReset: begin
        if (frame_tick) begin
          round_d = StFight;
        end
      end
      default: round_d = StFight;
    endcase

    // Kick sequencers run only while the round is (or stays) in FIGHT.
    for (int i = 0; i < 2; i++) begin
      if (round_d != StFight) begin
        kick_d[i] = KickIdle;
        kcnt_d[i] = '0;
      end else if (frame_tick) begin
        unique case (kick_q[i])
          KickIdle: begin
            if (btn[i] && !btn_q[i]) begin
              kick_d[i] = KickActive;
              kcnt_d[i] = KickActLoad;
            end
          end
          KickActive: begin
            if (kcnt_q[i] == '0) begin
              kick_d[i] = KickCool;
              kcnt_d[i] = KickCoolLoad;
            end else begin
              kcnt_d[i] = kcnt_q[i] - 1'b1;
            end
          end
          KickCool: begin
            if (kcnt_q[i] == '0) begin
              kick_d[i] = KickIdle;
            end else begin
              kcnt_d[i] = kcnt_q[i] - 1'b1;
            end
          end
          default: begin
            kick_d[i] = KickIdle;
            kcnt_d[i] = '0;
          end
        endcase
      end
    end

    bar_d = BarEdge - health_d[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round_q       <= StFight;
      winner_q      <= '0;
      round_reset_q <= 1'b0;
      ko_cnt_q      <= '0;
      health_q      <= {HealthMax, HealthMax};
      bar_q         <= BarReset;
      inv_q         <= '0;
      hit_q         <= '0;
      btn_q         <= '0;
      kcnt_q        <= '0;
      for (int i = 0; i < 2; i++) begin
        kick_q[i] <= KickIdle;
      end
    end else begin
      round_q       <= round_d;
      winner_q      <= winner_d;
      round_reset_q <= round_reset_d;
      ko_cnt_q      <= ko_cnt_d;
      health_q      <= health_d;
      bar_q         <= bar_d;
      inv_q         <= inv_d;
      hit_q         <= hit_d;
      btn_q         <= btn_d;
      kcnt_q        <= kcnt_d;
      for (int i = 0; i < 2; i++) begin
        kick_q[i] <= kick_d[i];
      end
    end
  end

  assign p1_kick_active = (kick_q[0] == KickActive);
  assign p2_kick_active = (kick_q[1] == KickActive);
  assign p1_health      = health_q[0];
  assign p2_health      = health_q[1];
  assign p2_bar_xpos    = bar_q;
  assign round_state    = round_q;
  assign winner         = winner_q;
  assign round_reset    = round_reset_q;

endmodule

// File: tb/tb_fight_referee.sv
// Directed bench for fight_referee: stimulus queues expected output values, a negedge
// monitor pops and compares them against the DUT.
module tb_fight_referee;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       p1_hit_px, p2_hit_px;
  logic       p1_kick_btn, p2_kick_btn;
  logic       p1_kick_active, p2_kick_active;
  logic [9:0] p1_health, p2_health, p2_bar_xpos;
  logic [1:0] round_state, winner;
  logic       round_reset;

  always #5 clk = ~clk;

  fight_referee dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .p1_hit_px     (p1_hit_px),
    .p2_hit_px     (p2_hit_px),
    .p1_kick_btn   (p1_kick_btn),
    .p2_kick_btn   (p2_kick_btn),
    .p1_kick_active(p1_kick_active),
    .p2_kick_active(p2_kick_active),
    .p1_health     (p1_health),
    .p2_health     (p2_health),
    .p2_bar_xpos   (p2_bar_xpos),
    .round_state   (round_state),
    .winner        (winner),
    .round_reset   (round_reset)
  );

  string exp_name[$];
  int    exp_sel[$];
  int    exp_val[$];
  int    n_vec  = 0;
  int    n_fail = 0;

  // Bench-side event counters: round_reset high cycles, and frames with p1 kick active.
  logic cnt_clr;
  int   rr_cnt;
  int   k1_cnt;
  always @(negedge clk) begin
    if (cnt_clr) begin
      rr_cnt <= 0;
      k1_cnt <= 0;
    end else begin
      if (round_reset) rr_cnt <= rr_cnt + 1;
      if (frame_tick && p1_kick_active) k1_cnt <= k1_cnt + 1;
    end
  end

  function automatic int observe(input int sel);
    case (sel)
      0:       return int'(p1_health);
      1:       return int'(p2_health);
      2:       return int'(p2_bar_xpos);
      3:       return int'(round_state);
      4:       return int'(winner);
      5:       return int'(p1_kick_active);
      6:       return int'(p2_kick_active);
      7:       return int'(round_reset);
      8:       return rr_cnt;
      9:       return k1_cnt;
      default: return -1;
    endcase
  endfunction

  initial begin
    string nm;
    int    sel, val, act;
    forever begin
      @(negedge clk);
      while (exp_sel.size() > 0) begin
        nm  = exp_name.pop_front();
        sel = exp_sel.pop_front();
        val = exp_val.pop_front();
        act = observe(sel);
        n_vec++;
        if (act != val) begin
          n_fail++;
          $display("FAIL %s: got %0d, expected %0d", nm, act, val);
        end
      end
    end
  end

  task automatic expect_val(input string nm, input int sel, input int val);
    exp_name.push_back(nm);
    exp_sel.push_back(sel);
    exp_val.push_back(val);
  endtask

  task automatic expect_reset(input string tag);
    expect_val({tag, "_p1_health"}, 0, 300);
    expect_val({tag, "_p2_health"}, 1, 300);
    expect_val({tag, "_bar_xpos"}, 2, 340);
    expect_val({tag, "_round_state"}, 3, 0);
    expect_val({tag, "_winner"}, 4, 0);
    expect_val({tag, "_p1_kick"}, 5, 0);
    expect_val({tag, "_p2_kick"}, 6, 0);
    expect_val({tag, "_round_reset"}, 7, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One video frame: hits for n clks, one quiet clk, then the tick; returns just after the tick.
  task automatic run_frame(input logic h1, input logic h2, input logic b1, input logic b2,
                           input int n);
    p1_kick_btn = b1;
    p2_kick_btn = b2;
    p1_hit_px   = h1;
    p2_hit_px   = h2;
    repeat (n) step();
    p1_hit_px  = 1'b0;
    p2_hit_px  = 1'b0;
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic idle_frames(input int count, input logic b1);
    repeat (count) run_frame(1'b0, 1'b0, b1, 1'b0, 3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_tick = 1'b0; cnt_clr = 1'b1;
    p1_hit_px = 1'b0; p2_hit_px = 1'b0; p1_kick_btn = 1'b0; p2_kick_btn = 1'b0;
    step();
    step();
    rst = 1'b0;
    cnt_clr = 1'b0;
    expect_reset("reset");

    // Single hit integrated over many pixels, applied only at the tick.
    p2_hit_px = 1'b1;
    repeat (50) step();
    p2_hit_px = 1'b0;
    step();
    expect_val("midframe_p2_health", 1, 300);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    expect_val("hit1_p1_health", 0, 300);
    expect_val("hit1_p2_health", 1, 200);
    expect_val("hit1_bar_xpos", 2, 440);

    // Invulnerability: ticks 2..31 ignore hits, tick 32 lands.
    repeat (2) run_frame(1'b0, 1'b1, 1'b0, 1'b0, 3);
    expect_val("inv_f3_p2_health", 1, 200);
    idle_frames(27, 1'b0);
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, 3);
    expect_val("inv_f31_p2_health", 1, 200);
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, 3);
    expect_val("inv_f32_p2_health", 1, 100);
    expect_val("inv_f32_bar_xpos", 2, 540);

    // Knock p1 out.
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 3);
    expect_val("ko_p1_200", 0, 200);
    idle_frames(30, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 3);
    expect_val("ko_p1_100", 0, 100);
    idle_frames(30, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 3);
    expect_val("ko_p1_0", 0, 0);
    expect_val("ko_p2_health", 1, 100);
    expect_val("ko_round_state", 3, 1);
    expect_val("ko_winner", 4, 2);

    // KO hold: hits and buttons ignored; restart on the 120th tick.
    repeat (2) run_frame(1'b0, 1'b1, 1'b0, 1'b0, 3);
    expect_val("ko_frozen_p2_health", 1, 100);
    run_frame(1'b0, 1'b0, 1'b1, 1'b0, 3);
    expect_val("ko_no_kick", 5, 0);
    idle_frames(116, 1'b0);
    expect_val("ko_hold_119", 3, 1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    idle_frames(1, 1'b0);
    expect_val("restart_round_reset", 7, 1);
    expect_val("restart_round_state", 3, 2);
    expect_val("restart_p1_health", 0, 300);
    expect_val("restart_p2_health", 1, 300);
    expect_val("restart_bar_xpos", 2, 340);
    expect_val("restart_winner", 4, 0);
    step();
    expect_val("restart_pulse_end", 7, 0);
    expect_val("restart_pulse_count", 8, 1);
    idle_frames(1, 1'b0);
    expect_val("restart_fight", 3, 0);

    // Draw: both reach zero on the same tick.
    run_frame(1'b1, 1'b1, 1'b0, 1'b0, 3);
    expect_val("draw_p1_200", 0, 200);
    expect_val("draw_p2_200", 1, 200);
    idle_frames(30, 1'b0);
    run_frame(1'b1, 1'b1, 1'b0, 1'b0, 3);
    expect_val("draw_p1_100", 0, 100);
    expect_val("draw_p2_100", 1, 100);
    idle_frames(30, 1'b0);
    run_frame(1'b1, 1'b1, 1'b0, 1'b0, 3);
    expect_val("draw_p1_0", 0, 0);
    expect_val("draw_p2_0", 1, 0);
    expect_val("draw_bar_xpos", 2, 640);
    expect_val("draw_round_state", 3, 1);
    expect_val("draw_winner", 4, 3);

    // Reset in the middle of KO: no round_reset pulse.
    idle_frames(1, 1'b0);
    cnt_clr = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt_clr = 1'b0;
    expect_reset("rst_ko");
    step();
    expect_val("rst_ko_no_pulse", 8, 0);

    // Kick: held button gives exactly 8 active frames and never retriggers.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    idle_frames(1, 1'b1);
    expect_val("kick_start", 5, 1);
    idle_frames(7, 1'b1);
    expect_val("kick_frame8", 5, 1);
    idle_frames(1, 1'b1);
    expect_val("kick_frame9", 5, 0);
    idle_frames(31, 1'b1);
    expect_val("kick_hold_no_retrigger", 5, 0);
    expect_val("kick_active_frames", 9, 8);

    // Press during cooldown is ignored; press after cooldown starts a new kick.
    idle_frames(1, 1'b0);
    idle_frames(1, 1'b1);
    expect_val("kick2_start", 5, 1);
    expect_val("kick2_p2_idle", 6, 0);
    idle_frames(9, 1'b0);
    idle_frames(1, 1'b1);
    expect_val("kick_cooldown_press", 5, 0);
    idle_frames(15, 1'b0);
    idle_frames(1, 1'b1);
    expect_val("kick3_start", 5, 1);

    // Reset during an active kick; history cleared so a held button re-arms.
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_reset("rst_kick");
    idle_frames(1, 1'b1);
    expect_val("kick_after_rst", 5, 1);

    repeat (4) @(negedge clk);
    #1;
    if (exp_sel.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", exp_sel.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fight_referee.md
Name: fight_referee

Overview:
- Game-logic stage directly downstream of the per-pixel hit detection in the fighting top level.
- Integrates per-pixel hit overlaps into at most one damage event per player per frame, and sequences kicks with fixed active and cooldown windows.
- Owns player health and produces health-bar geometry for the bar drawboxes.
- Runs the round state machine (FIGHT / KO / RESET) and pulses a round reset to re-home player positions.

Parameters:
- MAX_HEALTH, 300: health loaded at reset and at round restart; must be ≤ 1023.
- DAMAGE, 100: health removed per registered hit.
- INVULN_FRAMES, 30: frames a player ignores further hits after taking damage.
- KICK_FRAMES, 8: frames a kick stays active.
- KICK_COOLDOWN, 16: frames after a kick ends before a new kick may start.
- KO_HOLD_FRAMES, 120: frames the KO state is held before restart.
- BAR_RIGHT_EDGE, 640: x coordinate of the right end of the p2 health bar.

Ports:
- clk, input, 1: system clock; the only clock.
- rst, input, 1: reset; synchronous, active-high.
- frame_tick, input, 1: one-clk pulse at start of vertical blank, from the sync generator.
- p1_hit_px, input, 1: p2 kick overlaps p1 at the current pixel.
- p2_hit_px, input, 1: p1 kick overlaps p2 at the current pixel.
- p1_kick_btn, input, 1: raw kick switch, p1.
- p2_kick_btn, input, 1: raw kick switch, p2.
- p1_kick_active, output, 1: gate for p1 kick graphics and hit detection.
- p2_kick_active, output, 1: same, p2.
- p1_health, output, 10: p1 health bar width.
- p2_health, output, 10: p2 health bar width.
- p2_bar_xpos, output, 10: left x of the p2 bar.
- round_state, output, 2: 0 = FIGHT, 1 = KO, 2 = RESET.
- winner, output, 2: 0 = none, 1 = p1, 2 = p2, 3 = draw.
- round_reset, output, 1: one-clk pulse; top level re-homes players.

Behaviour:
- **Reset values (rst high at a clk edge):**
  - health = MAX_HEALTH for both players.
  - p2_bar_xpos = BAR_RIGHT_EDGE − MAX_HEALTH.
  - State FIGHT, winner 0, round_reset 0.
  - kick_active 0; all counters, hit flags and button history cleared.
  - rst mid-KO or mid-kick aborts immediately, with no round_reset pulse.
- **Frame tick:**
  - All game updates occur only on clk edges where frame_tick = 1.
  - Between ticks only the sticky hit flags change.
- **Hit flags:**
  - pN_hit_px = 1 on any non-tick cycle sets flag N.
  - On a tick cycle the flag is consumed and then cleared.
  - A hit_px asserted on the tick cycle itself is dropped; it cannot occur in valid video timing.
- **Damage (tick, state FIGHT, flag N set, invuln_N = 0):**
  - health_N ← health_N − DAMAGE, saturating at 0.
  - Unsigned 10-bit arithmetic with compare-before-subtract; no wrap.
  - invuln_N ← INVULN_FRAMES.
  - If invuln_N ≠ 0 the flag is discarded.
  - invuln_N decrements once per tick while nonzero; load takes priority over decrement.
- **p2 bar geometry:**
  - p2_bar_xpos = BAR_RIGHT_EDGE − p2_health, registered and updated in the same cycle as p2_health.
  - The bar is therefore right-aligned.
- **Kick sequencer, per player (IDLE → ACTIVE → COOLDOWN → IDLE):**
  - Button is sampled only on ticks; history updates every tick, in every state.
  - IDLE → ACTIVE on a tick where btn = 1 and the previous sample was 0 (rising edge).
  - ACTIVE: kick_active = 1 for exactly KICK_FRAMES ticks, then COOLDOWN.
  - COOLDOWN: exactly KICK_COOLDOWN ticks, then IDLE.
  - Holding the button never retriggers.
  - Outside FIGHT the sequencer is forced to IDLE with kick_active 0.
- **Round FSM:**
  - **FIGHT:** evaluated after the damage update of the same tick.
    - If either health = 0: → KO with winner = 1 if p2 = 0 only, 2 if p1 = 0 only, 3 if both.
    - KO hold counter ← KO_HOLD_FRAMES.
  - **KO:**
    - Hits and buttons are ignored; health is frozen.
    - Counter decrements per tick; on the tick where it reaches 0 → RESET.
  - **RESET:**
    - On the first clk in RESET: round_reset = 1 for one clk.
    - health ← MAX_HEALTH, winner ← 0, invuln and hit flags cleared.
    - On the next tick → FIGHT.
- **Latency:** a hit in frame k updates health and outputs 1 clk after tick k; no outputs change mid-frame except flags, which are internal.

Test Plan:
- **Single hit:** rst, pulse p2_hit_px for 50 clks, then tick → p2_health = 200, p2_bar_xpos = 440, p1_health = 300.
- **Invulnerability:** hit p2 in 3 consecutive frames → health 200 after the first; frames 2–3 ignored. Hit again at frame 31 after the first → 100.
- **KO and restart:** reduce p1 to 0 → round_state = 1, winner = 2. After 120 ticks, round_reset pulses exactly 1 clk, both healths = 300, next tick round_state = 0.
- **Draw:** both players at 100, both hit in the same frame → both 0 on the same tick, winner = 3.
- **Kick timing:** hold p1_kick_btn high for 40 frames → kick_active high for exactly 8 ticks, no retrigger. Release, press 10 ticks later (during cooldown) → ignored. Press after cooldown → active again.
- **Reset mid-operation:** assert rst during KO or an active kick → next clk all outputs at reset values, round_reset stays 0.
